// File: rtl/dsp_pkg.sv
// Shared types for the two-port dsp arbiter: opcode set, legality check and
// sequencer state encoding.
package dsp_pkg;

  typedef enum logic [3:0] {
    CMD_0  = 4'd0,
    CMD_2  = 4'd2,
    CMD_3  = 4'd3,
    CMD_4  = 4'd4,
    CMD_6  = 4'd6,
    CMD_7  = 4'd7,
    CMD_8  = 4'd8,
    CMD_9  = 4'd9,
    CMD_10 = 4'd10
  } dsp_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  function automatic logic is_legal_cmd(logic [3:0] cmd);
    logic legal;
    case (cmd)
      CMD_0, CMD_2, CMD_3, CMD_4, CMD_6,
      CMD_7, CMD_8, CMD_9, CMD_10: legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, ties go to the port that was
// not granted most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last_grant_reg ? 2'b01 : 2'b10;
  end

  // Resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)                  last_grant_reg <= 1'b1;
    else if (update && |grant)  last_grant_reg <= grant[1];
  end

endmodule

// File: rtl/dsp_arb.sv
// Shares one combinational dsp multiplier between two requesters: registers the
// winning operands onto the dsp, waits SETTLE cycles, returns the result.
module dsp_arb
  import dsp_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_command,
  input  logic [31:0] req0_in_1,
  input  logic [31:0] req0_in_2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_command,
  input  logic [31:0] req1_in_1,
  input  logic [31:0] req1_in_2,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [63:0] resp0_result,
  output logic        resp0_error,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [63:0] resp1_result,
  output logic        resp1_error,
  output logic [31:0] dsp_command,
  output logic [31:0] dsp_in_1,
  output logic [31:0] dsp_in_2,
  input  logic [63:0] dsp_result,
  output logic [15:0] op_count
);

  arb_state_t  state_reg, state_next;
  logic        owner_reg;
  logic [3:0]  settle_cnt_reg;
  logic [63:0] result_reg;
  logic        error_reg;
  logic [15:0] op_count_reg;
  logic [3:0]  dsp_cmd_reg;
  logic [31:0] dsp_in_1_reg, dsp_in_2_reg;

  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, grant;
  logic [3:0]  req_cmd [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic        accept, accept_port, accept_legal, resp_fire;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_cmd[0] = req0_command;
  assign req_cmd[1] = req1_command;
  assign req_a[0]   = req0_in_1;
  assign req_a[1]   = req1_in_1;
  assign req_b[0]   = req0_in_2;
  assign req_b[1]   = req1_in_2;

  // Arbitration only matters in IDLE; outside it the grant is forced to zero.
  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid & {2{state_reg == IDLE}}),
    .update (accept),
    .grant  (grant)
  );

  assign accept       = |req_ready;
  assign accept_port  = req_ready[1];
  assign accept_legal = is_legal_cmd(req_cmd[accept_port]);
  assign resp_fire    = |(resp_valid & resp_ready);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = accept_legal ? ISSUE : RESP;
      ISSUE:   if (settle_cnt_reg == 4'd0) state_next = RESP;
      RESP:    if (resp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    if (!reset) begin
      if (state_reg == IDLE) req_ready = grant;
      if (state_reg == RESP) resp_valid[owner_reg] = 1'b1;
    end
  end

  // The dsp_* registers are only written on a legal accept so the multiplier
  // inputs stay quiet between operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg      <= 1'b0;
      settle_cnt_reg <= 4'd0;
      result_reg     <= '0;
      error_reg      <= 1'b0;
      dsp_cmd_reg    <= 4'd0;
      dsp_in_1_reg   <= '0;
      dsp_in_2_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg <= accept_port;
            if (accept_legal) begin
              dsp_cmd_reg    <= req_cmd[accept_port];
              dsp_in_1_reg   <= req_a[accept_port];
              dsp_in_2_reg   <= req_b[accept_port];
              settle_cnt_reg <= 4'(SETTLE - 1);
            end else begin
              result_reg <= '0;
              error_reg  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (settle_cnt_reg != 4'd0) begin
            settle_cnt_reg <= settle_cnt_reg - 4'd1;
          end else begin
            result_reg <= dsp_result;
            error_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) op_count_reg <= '0;
    else       op_count_reg <= op_count_reg + {15'd0, resp_fire};
  end

  assign req0_ready   = req_ready[0];
  assign req1_ready   = req_ready[1];
  assign resp0_valid  = resp_valid[0];
  assign resp1_valid  = resp_valid[1];
  assign resp0_result = result_reg;
  assign resp1_result = result_reg;
  assign resp0_error  = error_reg;
  assign resp1_error  = error_reg;
  assign dsp_command  = {28'd0, dsp_cmd_reg};
  assign dsp_in_1     = dsp_in_1_reg;
  assign dsp_in_2     = dsp_in_2_reg;
  assign op_count     = op_count_reg;

endmodule
